// File: rtl/ram_access_ctrl_pkg.sv
// Shared widths, depth and FSM state encoding for the RAM access controller.
package ram_ctrl_pkg;
    localparam int ADDR_W_DFLT = 5;
    localparam int DATA_W_DFLT = 4;
    localparam int DEPTH       = 2**ADDR_W_DFLT;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request/grant, clear-control and RAM-port bundle between the lab top level and the controller.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W_DFLT,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W_DFLT
);
    logic              tick;
    logic              scan_hold;
    logic              clear_start;
    logic [DATA_W-1:0] clear_data;
    logic [1:0]        wr_req;
    logic [ADDR_W-1:0] wr_addr0;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data0;
    logic [DATA_W-1:0] wr_data1;
    logic [1:0]        wr_gnt;
    logic              busy;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddress;
    logic [DATA_W-1:0] ram_data;
    logic [ADDR_W-1:0] ram_rdaddress;

    modport master (
        output tick, scan_hold, clear_start, clear_data,
               wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  wr_gnt, busy, ram_wren, ram_wraddress, ram_data, ram_rdaddress
    );

    modport slave (
        input  tick, scan_hold, clear_start, clear_data,
               wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output wr_gnt, busy, ram_wren, ram_wraddress, ram_data, ram_rdaddress
    );
endinterface

// File: rtl/ram_access_ctrl_arb.sv
// Two-requester round-robin arbiter; combinational one-hot grant, last winner remembered.
// last_gnt resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last_gnt <= 1'b1;
        else if (|gnt)
            last_gnt <= gnt[1];
    end
endmodule

// File: rtl/ram_access_ctrl.sv
// Write-port arbiter + bulk-clear sequencer and free-running read scanner for the 32x4 RAM.
// All outputs registered: a grant or clear write appears the cycle after the request is sampled.
module ram_access_ctrl #(
    parameter int ADDR_W = ram_ctrl_pkg::ADDR_W_DFLT,
    parameter int DATA_W = ram_ctrl_pkg::DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_access_ctrl_if.slave  bus
);
    import ram_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] fill;
    logic [1:0]        arb_gnt;
    logic              arb_en;

    // A clear request in IDLE pre-empts any write requested in the same cycle.
    assign arb_en = (state == IDLE) && !bus.clear_start;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.wr_req),
        .enable  (arb_en),
        .gnt     (arb_gnt)
    );

    // clr_cnt always equals the address currently presented on ram_wraddress during CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            clr_cnt           <= '0;
            fill              <= '0;
            bus.busy          <= 1'b0;
            bus.wr_gnt        <= 2'b00;
            bus.ram_wren      <= 1'b0;
            bus.ram_wraddress <= '0;
            bus.ram_data      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clear_start) begin
                        state             <= CLEAR;
                        clr_cnt           <= '0;
                        fill              <= bus.clear_data;
                        bus.busy          <= 1'b1;
                        bus.wr_gnt        <= 2'b00;
                        bus.ram_wren      <= 1'b1;
                        bus.ram_wraddress <= '0;
                        bus.ram_data      <= bus.clear_data;
                    end else begin
                        bus.wr_gnt   <= arb_gnt;
                        bus.ram_wren <= |arb_gnt;
                        if (arb_gnt[1]) begin
                            bus.ram_wraddress <= bus.wr_addr1;
                            bus.ram_data      <= bus.wr_data1;
                        end else if (arb_gnt[0]) begin
                            bus.ram_wraddress <= bus.wr_addr0;
                            bus.ram_data      <= bus.wr_data0;
                        end
                    end
                end
                CLEAR: begin
                    bus.wr_gnt <= 2'b00;
                    if (clr_cnt == {ADDR_W{1'b1}}) begin
                        state        <= IDLE;
                        clr_cnt      <= '0;
                        bus.busy     <= 1'b0;
                        bus.ram_wren <= 1'b0;
                    end else begin
                        clr_cnt           <= clr_cnt + ONE_A;
                        bus.ram_wren      <= 1'b1;
                        bus.ram_wraddress <= clr_cnt + ONE_A;
                        bus.ram_data      <= fill;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Display scan address; deliberately unaware of writes and clears.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.ram_rdaddress <= '0;
        else if (bus.tick && !bus.scan_hold)
            bus.ram_rdaddress <= bus.ram_rdaddress + ONE_A;
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench: vector table, hand-written clear/scan/reset sequences, random run vs. model.
module tb_ram_access_ctrl;
    import ram_ctrl_pkg::*;

    localparam int AW = 5;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          tick;
        logic          hold;
        logic [1:0]    gnt;
        logic          wren;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [AW-1:0] rd;
    } vec_t;

    vec_t tbl [8];

    // reference model state
    int            m_rem;
    logic [DW-1:0] m_fill;
    int            m_last;
    int            m_rd;
    logic [1:0]    e_gnt;
    logic          e_wren;
    logic          e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    logic [1:0]    r_req;
    logic [AW-1:0] r_a [2];
    logic [DW-1:0] r_d [2];
    logic [AW-1:0] exp_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic w, input logic b,
                             input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [AW-1:0] rd);
        chk({tag, ".wr_gnt"},   32'(bus.wr_gnt),        32'(g));
        chk({tag, ".ram_wren"}, 32'(bus.ram_wren),      32'(w));
        chk({tag, ".busy"},     32'(bus.busy),          32'(b));
        chk({tag, ".rdaddr"},   32'(bus.ram_rdaddress), 32'(rd));
        if (w) begin
            chk({tag, ".wraddr"}, 32'(bus.ram_wraddress), 32'(a));
            chk({tag, ".data"},   32'(bus.ram_data),      32'(d));
        end
    endtask

    task automatic inputs_idle();
        bus.tick        = 1'b0;
        bus.scan_hold   = 1'b0;
        bus.clear_start = 1'b0;
        bus.clear_data  = '0;
        bus.wr_req      = 2'b00;
        bus.wr_addr0    = '0;
        bus.wr_addr1    = '0;
        bus.wr_data0    = '0;
        bus.wr_data1    = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        inputs_idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Behavioural model: one call per rising edge, using the inputs about to be sampled.
    task automatic model_step();
        e_gnt  = 2'b00;
        e_wren = 1'b0;
        e_busy = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem > 0) begin
                e_busy = 1'b1;
                e_wren = 1'b1;
                e_addr = AW'(DEPTH - m_rem);
                e_data = m_fill;
            end
        end else if (bus.clear_start) begin
            m_rem  = DEPTH;
            m_fill = bus.clear_data;
            e_busy = 1'b1;
            e_wren = 1'b1;
            e_addr = '0;
            e_data = bus.clear_data;
        end else if (bus.wr_req != 2'b00) begin
            int w;
            if (bus.wr_req == 2'b01)      w = 0;
            else if (bus.wr_req == 2'b10) w = 1;
            else                          w = (m_last == 1) ? 0 : 1;
            m_last = w;
            e_gnt  = (w == 0) ? 2'b01 : 2'b10;
            e_wren = 1'b1;
            e_addr = (w == 0) ? bus.wr_addr0 : bus.wr_addr1;
            e_data = (w == 0) ? bus.wr_data0 : bus.wr_data1;
        end
        if (bus.tick && !bus.scan_hold)
            m_rd = (m_rd + 1) % DEPTH;
    endtask

    initial begin
        tbl[0] = '{2'b11, 5'h04, 4'h1, 5'h09, 4'h6, 1'b1, 1'b0, 2'b01, 1'b1, 5'h04, 4'h1, 5'h01};
        tbl[1] = '{2'b11, 5'h0A, 4'h2, 5'h0B, 4'h7, 1'b1, 1'b1, 2'b10, 1'b1, 5'h0B, 4'h7, 5'h01};
        tbl[2] = '{2'b11, 5'h1F, 4'hF, 5'h00, 4'h0, 1'b1, 1'b0, 2'b01, 1'b1, 5'h1F, 4'hF, 5'h02};
        tbl[3] = '{2'b11, 5'h10, 4'h3, 5'h15, 4'hC, 1'b0, 1'b0, 2'b10, 1'b1, 5'h15, 4'hC, 5'h02};
        tbl[4] = '{2'b00, 5'h00, 4'h0, 5'h00, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'h00, 4'h0, 5'h02};
        tbl[5] = '{2'b01, 5'h03, 4'hA, 5'h00, 4'h0, 1'b0, 1'b0, 2'b01, 1'b1, 5'h03, 4'hA, 5'h02};
        tbl[6] = '{2'b00, 5'h00, 4'h0, 5'h00, 4'h0, 1'b0, 1'b0, 2'b00, 1'b0, 5'h00, 4'h0, 5'h02};
        tbl[7] = '{2'b10, 5'h00, 4'h0, 5'h1E, 4'h9, 1'b1, 1'b0, 2'b10, 1'b1, 5'h1E, 4'h9, 5'h03};

        // reset state
        do_reset();
        chk("rst.wr_gnt",   32'(bus.wr_gnt),        32'd0);
        chk("rst.ram_wren", 32'(bus.ram_wren),      32'd0);
        chk("rst.busy",     32'(bus.busy),          32'd0);
        chk("rst.wraddr",   32'(bus.ram_wraddress), 32'd0);
        chk("rst.data",     32'(bus.ram_data),      32'd0);
        chk("rst.rdaddr",   32'(bus.ram_rdaddress), 32'd0);

        // vector table: contention, single write, scan hold
        for (int i = 0; i < 8; i++) begin
            bus.wr_req    = tbl[i].req;
            bus.wr_addr0  = tbl[i].a0;
            bus.wr_data0  = tbl[i].d0;
            bus.wr_addr1  = tbl[i].a1;
            bus.wr_data1  = tbl[i].d1;
            bus.tick      = tbl[i].tick;
            bus.scan_hold = tbl[i].hold;
            @(negedge clk);
            check_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].wren, 1'b0,
                      tbl[i].addr, tbl[i].data, tbl[i].rd);
        end
        inputs_idle();
        exp_rd = 5'h03;

        // clear with fill 5, requester 1 raised mid-clear
        bus.clear_start = 1'b1;
        bus.clear_data  = 4'h5;
        @(negedge clk);
        check_all("clr5.c0", 2'b00, 1'b1, 1'b1, 5'd0, 4'h5, exp_rd);
        bus.clear_start = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            check_all($sformatf("clr5.c%0d", i), 2'b00, 1'b1, 1'b1, AW'(i), 4'h5, exp_rd);
            if (i == 10) begin
                bus.wr_req   = 2'b10;
                bus.wr_addr1 = 5'h07;
                bus.wr_data1 = 4'h2;
            end
        end
        @(negedge clk);
        check_all("clr5.end", 2'b00, 1'b0, 1'b0, 5'd0, 4'h0, exp_rd);
        @(negedge clk);
        check_all("clr5.gnt", 2'b10, 1'b1, 1'b0, 5'h07, 4'h2, exp_rd);
        bus.wr_req = 2'b00;
        @(negedge clk);
        check_all("clr5.after", 2'b00, 1'b0, 1'b0, 5'd0, 4'h0, exp_rd);

        // clear beats same-cycle write; second clear_start mid-clear ignored
        bus.clear_start = 1'b1;
        bus.clear_data  = 4'hC;
        bus.wr_req      = 2'b01;
        bus.wr_addr0    = 5'h01;
        bus.wr_data0    = 4'h3;
        @(negedge clk);
        check_all("clrC.c0", 2'b00, 1'b1, 1'b1, 5'd0, 4'hC, exp_rd);
        bus.clear_start = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            @(negedge clk);
            check_all($sformatf("clrC.c%0d", i), 2'b00, 1'b1, 1'b1, AW'(i), 4'hC, exp_rd);
            bus.clear_start = (i == 10);
            bus.clear_data  = (i == 10) ? 4'hF : 4'h0;
        end
        @(negedge clk);
        check_all("clrC.end", 2'b00, 1'b0, 1'b0, 5'd0, 4'h0, exp_rd);
        @(negedge clk);
        check_all("clrC.gnt", 2'b01, 1'b1, 1'b0, 5'h01, 4'h3, exp_rd);
        inputs_idle();

        // scan wrap and hold
        do_reset();
        bus.tick = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            chk($sformatf("scan.t%0d", i), 32'(bus.ram_rdaddress), 32'(i % DEPTH));
        end
        bus.scan_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("scan.hold%0d", i), 32'(bus.ram_rdaddress), 32'd1);
        end
        inputs_idle();

        // async reset in the middle of a clear
        do_reset();
        bus.tick = 1'b1;
        repeat (3) @(negedge clk);
        bus.tick = 1'b0;
        chk("areset.rd_pre", 32'(bus.ram_rdaddress), 32'd3);
        bus.clear_start = 1'b1;
        bus.clear_data  = 4'h9;
        @(negedge clk);
        bus.clear_start = 1'b0;
        repeat (12) @(negedge clk);
        chk("areset.busy_pre",   32'(bus.busy),          32'd1);
        chk("areset.wraddr_pre", 32'(bus.ram_wraddress), 32'd12);
        #2 reset_n = 1'b0;
        #1;
        chk("areset.busy",   32'(bus.busy),          32'd0);
        chk("areset.wren",   32'(bus.ram_wren),      32'd0);
        chk("areset.gnt",    32'(bus.wr_gnt),        32'd0);
        chk("areset.rdaddr", 32'(bus.ram_rdaddress), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check_all("areset.idle", 2'b00, 1'b0, 1'b0, 5'd0, 4'h0, 5'd0);
        bus.wr_req   = 2'b11;
        bus.wr_addr0 = 5'h02;
        bus.wr_data0 = 4'h4;
        bus.wr_addr1 = 5'h03;
        bus.wr_data1 = 4'h5;
        @(negedge clk);
        check_all("areset.tie", 2'b01, 1'b1, 1'b0, 5'h02, 4'h4, 5'd0);
        inputs_idle();

        // random traffic against the model
        do_reset();
        m_rem  = 0;
        m_fill = '0;
        m_last = 1;
        m_rd   = 0;
        e_gnt  = 2'b00;
        r_req  = 2'b00;
        e_addr = '0;
        e_data = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!r_req[k] || e_gnt[k]) begin
                    r_req[k] = 1'($urandom_range(0, 1));
                    r_a[k]   = AW'($urandom);
                    r_d[k]   = DW'($urandom);
                end
            end
            bus.wr_req      = r_req;
            bus.wr_addr0    = r_a[0];
            bus.wr_data0    = r_d[0];
            bus.wr_addr1    = r_a[1];
            bus.wr_data1    = r_d[1];
            bus.clear_start = ($urandom_range(0, 39) == 0);
            bus.clear_data  = DW'($urandom);
            bus.tick        = 1'($urandom_range(0, 1));
            bus.scan_hold   = ($urandom_range(0, 3) == 0);
            model_step();
            @(negedge clk);
            check_all("rand", e_gnt, e_wren, e_busy, e_addr, e_data, AW'(m_rd));
        end
        inputs_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
